// File: rtl/digital_gain_ctrl_if.sv
// Sample/peak bus between the gain stage and digital_gain_ctrl.
// Optional manual override signals exist only with DIGITAL_GAIN_MANUAL_EN.
interface digital_gain_ctrl_if #(
  parameter int BITWIDTH = 7
);
  logic                en_sync_in;
  logic [BITWIDTH+1:0] cnt_sync_in;
  logic [31:0]         max_in;
  logic [15:0]         scaled_coeff;
  logic                coeff_update;
  logic [31:0]         frame_peak;
  logic                sat;
`ifdef DIGITAL_GAIN_MANUAL_EN
  logic                manual_mode;
  logic [15:0]         manual_coeff;

  modport master (
    output en_sync_in, cnt_sync_in, max_in, manual_mode, manual_coeff,
    input  scaled_coeff, coeff_update, frame_peak, sat
  );
  modport slave (
    input  en_sync_in, cnt_sync_in, max_in, manual_mode, manual_coeff,
    output scaled_coeff, coeff_update, frame_peak, sat
  );
`else
  modport master (
    output en_sync_in, cnt_sync_in, max_in,
    input  scaled_coeff, coeff_update, frame_peak, sat
  );
  modport slave (
    input  en_sync_in, cnt_sync_in, max_in,
    output scaled_coeff, coeff_update, frame_peak, sat
  );
`endif
endinterface

// File: rtl/digital_gain_ctrl.sv
// Frame-based automatic gain control: per-frame peak -> shift with fast attack, held decay.
// Optional manual override enabled by the macro DIGITAL_GAIN_MANUAL_EN.
module digital_gain_ctrl #(
  parameter int BITWIDTH    = 7,
  parameter int HEADROOM    = 1,
  parameter int HOLD_FRAMES = 4,
  parameter int INIT_SHIFT  = 8
) (
  input logic                clk,
  input logic                rst,
  digital_gain_ctrl_if.slave bus
);
  localparam int CW = BITWIDTH + 2;
  localparam logic signed [7:0] KNEE = 8'(14 - HEADROOM);

  function automatic logic signed [7:0] lead_one(input logic [31:0] v);
    logic signed [7:0] p;
    p = -8'sd1;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) p = 8'(i);
    end
    return p;
  endfunction

  logic [31:0]       peak_r;
  logic              seen_r;
  logic              v1_r;
  logic              v2_r;
  logic [4:0]        desired_r;
  logic [4:0]        shift_r;
  logic [7:0]        hold_cnt_r;
  logic [31:0]       frame_peak_r;
  logic              sat_r;
  logic              coeff_update_r;

  logic              is_start_s;
  logic              is_end_s;
  logic [31:0]       fp_s;
  logic signed [7:0] d_s;
  logic [4:0]        desired_s;

  // Frame markers, running maximum and clamped shift request
  always_comb begin
    is_start_s = bus.en_sync_in && (bus.cnt_sync_in == {CW{1'b0}});
    is_end_s   = bus.en_sync_in && (bus.cnt_sync_in == {CW{1'b1}});
    fp_s       = (peak_r > bus.max_in) ? peak_r : bus.max_in;
    d_s        = lead_one(frame_peak_r) - KNEE;
    if (d_s < 8'sd0) begin
      desired_s = 5'd0;
    end else if (d_s > 8'sd16) begin
      desired_s = 5'd16;
    end else begin
      desired_s = d_s[4:0];
    end
  end

  // Peak accumulation and frame-end capture
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_r       <= 32'd0;
      seen_r       <= 1'b0;
      v1_r         <= 1'b0;
      frame_peak_r <= 32'd0;
    end else begin
      v1_r <= is_end_s && seen_r;
      if (is_start_s) begin
        peak_r <= bus.max_in;
        seen_r <= 1'b1;
      end else if (bus.en_sync_in) begin
        peak_r <= fp_s;
        if (is_end_s) seen_r <= 1'b0;
      end
      if (is_end_s && seen_r) frame_peak_r <= fp_s;
    end
  end

  // Shift request and saturation flag from the captured frame peak
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r      <= 1'b0;
      desired_r <= 5'd0;
      sat_r     <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        desired_r <= desired_s;
        sat_r     <= (d_s > 8'sd16);
      end
    end
  end

  // Shift update: immediate attack, decay by one after HOLD_FRAMES quieter frames
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r        <= 5'(INIT_SHIFT);
      hold_cnt_r     <= 8'd0;
      coeff_update_r <= 1'b0;
    end else begin
      coeff_update_r <= v2_r;
`ifdef DIGITAL_GAIN_MANUAL_EN
      if (bus.manual_mode) begin
        shift_r    <= (bus.manual_coeff > 16'd16) ? 5'd16 : bus.manual_coeff[4:0];
        hold_cnt_r <= 8'd0;
      end else
`endif
      if (v2_r) begin
        if (desired_r > shift_r) begin
          shift_r    <= desired_r;
          hold_cnt_r <= 8'd0;
        end else if (desired_r < shift_r) begin
          if (hold_cnt_r + 8'd1 == 8'(HOLD_FRAMES)) begin
            shift_r    <= shift_r - 5'd1;
            hold_cnt_r <= 8'd0;
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end else begin
          hold_cnt_r <= 8'd0;
        end
      end
    end
  end

  assign bus.scaled_coeff = {11'd0, shift_r};
  assign bus.coeff_update = coeff_update_r;
  assign bus.frame_peak   = frame_peak_r;
  assign bus.sat          = sat_r;
endmodule

// File: tb/tb_digital_gain_ctrl.sv
// Directed bench for digital_gain_ctrl: attack, held decay, ignored frames, reset mid-frame
// and (with DIGITAL_GAIN_MANUAL_EN) the manual override.
module tb_digital_gain_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  digital_gain_ctrl_if #(.BITWIDTH(7)) bus ();

  digital_gain_ctrl #(
    .BITWIDTH(7), .HEADROOM(1), .HOLD_FRAMES(4), .INIT_SHIFT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Samples start..511 with one peak; returns at the negedge of cycle N+1
  task automatic run_frame(input int start, input int pk_idx, input logic [31:0] pk_val,
                           input int rst_idx);
    for (int i = start; i < 512; i++) begin
      @(negedge clk);
      bus.en_sync_in  = 1'b1;
      bus.cnt_sync_in = 9'(i);
      bus.max_in      = (i == pk_idx) ? pk_val : 32'd0;
      rst             = (i == rst_idx);
    end
    @(negedge clk);
    bus.en_sync_in = 1'b0;
    bus.max_in     = 32'd0;
    rst            = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] e_fp, input logic e_sat,
                             input logic [4:0] e_coeff, input logic e_upd);
    check({tag, ".frame_peak"}, bus.frame_peak, e_fp);
    @(negedge clk);
    check({tag, ".sat"}, 32'(bus.sat), 32'(e_sat));
    @(negedge clk);
    check({tag, ".scaled_coeff"}, 32'(bus.scaled_coeff), 32'(e_coeff));
    check({tag, ".coeff_update"}, 32'(bus.coeff_update), 32'(e_upd));
    @(negedge clk);
    check({tag, ".upd_low"}, 32'(bus.coeff_update), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [4:0] decay_exp [10];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst             = 1'b1;
    bus.en_sync_in  = 1'b0;
    bus.cnt_sync_in = 9'd0;
    bus.max_in      = 32'd0;
`ifdef DIGITAL_GAIN_MANUAL_EN
    bus.manual_mode  = 1'b0;
    bus.manual_coeff = 16'd0;
`endif
    decay_exp = '{5'd8, 5'd8, 5'd8, 5'd7, 5'd7, 5'd7, 5'd7, 5'd6, 5'd6, 5'd6};

    do_reset();
    check("rst.scaled_coeff", 32'(bus.scaled_coeff), 32'd8);
    check("rst.coeff_update", 32'(bus.coeff_update), 32'd0);
    check("rst.frame_peak", bus.frame_peak, 32'd0);
    check("rst.sat", 32'(bus.sat), 32'd0);

    // Large peak saturates the request and attacks to 16
    run_frame(0, 100, 32'h4000_0000, -1);
    check_frame("sat_frame", 32'h4000_0000, 1'b1, 5'd16, 1'b1);

    // p=16 -> desired 3: decay by one every 4 frames from 8
    do_reset();
    check("rst2.scaled_coeff", 32'(bus.scaled_coeff), 32'd8);
    for (int f = 0; f < 10; f++) begin
      run_frame(0, 37 + f, 32'h0001_0000, -1);
      check_frame($sformatf("decay%0d", f + 1), 32'h0001_0000, 1'b0, decay_exp[f], 1'b1);
    end

    // hold_cnt is 2 here; attack must clear it
    run_frame(0, 511, 32'h0800_0000, -1);
    check_frame("attack", 32'h0800_0000, 1'b0, 5'd14, 1'b1);
    for (int f = 0; f < 4; f++) begin
      run_frame(0, 0, 32'h0001_0000, -1);
      check_frame($sformatf("post_attack%0d", f + 1), 32'h0001_0000, 1'b0,
                  (f == 3) ? 5'd13 : 5'd14, 1'b1);
    end

    // Frame without index 0 is ignored
    run_frame(200, 300, 32'h4000_0000, -1);
    check_frame("no_start", 32'h0001_0000, 1'b0, 5'd13, 1'b0);

    // Reset mid-frame discards the frame
    run_frame(0, 100, 32'h4000_0000, 300);
    check_frame("rst_mid", 32'd0, 1'b0, 5'd8, 1'b0);

    // All-zero frame requests shift 0 but only advances the hold counter
    run_frame(0, 5, 32'd0, -1);
    check_frame("zero_peak", 32'd0, 1'b0, 5'd8, 1'b1);

`ifdef DIGITAL_GAIN_MANUAL_EN
    @(negedge clk);
    bus.manual_mode  = 1'b1;
    bus.manual_coeff = 16'd20;
    @(negedge clk);
    check("manual.scaled_coeff", 32'(bus.scaled_coeff), 32'd16);
    @(negedge clk);
    bus.manual_mode = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_frame(0, 250, 32'h0000_4000, -1);
      check_frame($sformatf("manual_decay%0d", f + 1), 32'h0000_4000, 1'b0,
                  (f == 3) ? 5'd15 : 5'd16, 1'b1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
